// File: rtl/io_timer_pkg.sv
// Shared definitions for the I/O-mapped timer: register map, CTRL/STAT bit layout, prescaler sizing.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package io_timer_pkg;

  localparam int DATA_W = 8;
  localparam int PS_W   = 3;

  // Register offsets within a bank (io_*addr[2:0]).
  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_STAT   = 3'd1,
    OFF_COUNT  = 3'd2,
    OFF_RELOAD = 3'd3,
    OFF_CMP    = 3'd4,
    OFF_PRESC  = 3'd5,
    OFF_RSVD6  = 3'd6,
    OFF_RSVD7  = 3'd7
  } reg_off_e;

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_ARL    = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PS_LSB = 3;

  // STAT bit positions.
  localparam int STAT_OVF = 0;
  localparam int STAT_CMF = 1;

  // Writable CTRL bits; the two reserved MSBs are never stored.
  localparam logic [DATA_W-1:0] CTRL_WMASK = 8'h3F;

  // CTRL register image, MSB first.
  typedef struct packed {
    logic [1:0]      rsvd;
    logic [PS_W-1:0] ps;
    logic            ie;
    logic            arl;
    logic            en;
  } ctrl_t;

  // Low-bit mask of the prescaler count that must be all ones for a tick:
  // ps=0 -> 8'h00 (every cycle), ps=7 -> 8'h7F (every 128 cycles).
  function automatic logic [DATA_W-1:0] ps_mask(input logic [PS_W-1:0] ps);
    logic [DATA_W-1:0] one;
    one = 8'h01;
    return (one << ps) - one;
  endfunction

endpackage

// File: rtl/io_timer_if.sv
// Memory-controller I/O bus seen by one timer: read address/data and write address/data/strobe.
// Latency: read data is registered by the slave, valid one cycle after the read address.
// Backpressure: none; the slave accepts every write and every read address.
interface io_timer_if;
  import io_timer_pkg::*;

  logic [4:0]        io_readaddr;
  logic [DATA_W-1:0] io_readdata;
  logic [4:0]        io_writeaddr;
  logic [DATA_W-1:0] io_writedata;
  logic              io_write_en;

  modport master (
    output io_readaddr,
    output io_writeaddr,
    output io_writedata,
    output io_write_en,
    input  io_readdata
  );

  modport slave (
    input  io_readaddr,
    input  io_writeaddr,
    input  io_writedata,
    input  io_write_en,
    output io_readdata
  );

endinterface

// File: rtl/io_timer_prescaler.sv
// Free-running 8-bit prescaler producing a timer tick when its low ps bits are all ones.
// Latency: tick is combinational from the registered count; count updates on the next edge.
// Backpressure: pause freezes the count and suppresses tick; clr returns the count to zero.
module timer_prescaler
  import io_timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              pause,
  input  logic [PS_W-1:0]   ps,
  output logic              tick,
  output logic [DATA_W-1:0] count
);

  logic [DATA_W-1:0] mask;
  logic              advance;

  assign mask    = ps_mask(ps);
  assign advance = en && !pause;
  assign tick    = advance && ((count & mask) == mask);

  // Count enabled, unstalled cycles; a clear restarts the division phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (advance) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// I/O-mapped 8-bit timer: CTRL/STAT/COUNT/RELOAD/CMP/PRESC registers, overflow and compare flags, level irq.
// Latency: registered read data one cycle after io_readaddr; writes take effect on the next edge.
// Backpressure: none; pause freezes counting and read data while writes are still accepted.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [1:0] BANK = 2'd0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pause,
  io_timer_if.slave bus,
  output logic      irq
);

  // Architectural state.
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] reload_q;
  logic [DATA_W-1:0] cmp_q;
  logic              ovf_q;
  logic              cmf_q;
  logic [DATA_W-1:0] rdata_q;

  // Write decode.
  logic              wr_hit;
  reg_off_e          wr_off;
  logic              wr_ctrl;
  logic              wr_stat;
  logic              wr_count;
  logic              wr_reload;
  logic              wr_cmp;
  ctrl_t             ctrl_wdata;

  // Counter datapath.
  logic              presc_clr;
  logic              tick;
  logic [DATA_W-1:0] presc_count;
  logic [DATA_W-1:0] tick_count;
  logic              tick_wrap;
  logic              ovf_set;
  logic              cmf_set;
  logic              ovf_clr;
  logic              cmf_clr;

  // Read decode.
  logic              rd_hit;
  reg_off_e          rd_off;
  logic [DATA_W-1:0] rd_mux;

  assign wr_hit     = bus.io_write_en && (bus.io_writeaddr[4:3] == BANK);
  assign wr_off     = reg_off_e'(bus.io_writeaddr[2:0]);
  assign wr_ctrl    = wr_hit && (wr_off == OFF_CTRL);
  assign wr_stat    = wr_hit && (wr_off == OFF_STAT);
  assign wr_count   = wr_hit && (wr_off == OFF_COUNT);
  assign wr_reload  = wr_hit && (wr_off == OFF_RELOAD);
  assign wr_cmp     = wr_hit && (wr_off == OFF_CMP);
  assign ctrl_wdata = ctrl_t'(bus.io_writedata & CTRL_WMASK);

  // Restart the prescaler phase when the timer is stopped or its rate changes.
  assign presc_clr = wr_ctrl && (!ctrl_wdata.en || (ctrl_wdata.ps != ctrl_q.ps));

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .clr   (presc_clr),
    .pause (pause),
    .ps    (ctrl_q.ps),
    .tick  (tick),
    .count (presc_count)
  );

  // Value COUNT takes on a tick: increment, or wrap to RELOAD/zero at 8'hFF.
  always_comb begin
    tick_count = count_q + 8'd1;
    tick_wrap  = 1'b0;
    if (count_q == 8'hFF) begin
      tick_wrap  = 1'b1;
      tick_count = ctrl_q.arl ? reload_q : 8'h00;
    end
  end

  // Hardware flag events; a compare match only counts when the tick actually lands in COUNT.
  assign ovf_set = tick && tick_wrap;
  assign cmf_set = tick && !wr_count && (tick_count == cmp_q);
  assign ovf_clr = wr_stat && bus.io_writedata[STAT_OVF];
  assign cmf_clr = wr_stat && bus.io_writedata[STAT_CMF];

  // CTRL register; reserved bits are masked off before storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= ctrl_wdata;
    end
  end

  // COUNT register; a CPU write overrides a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= bus.io_writedata;
    end else if (tick) begin
      count_q <= tick_count;
    end
  end

  // RELOAD and CMP are plain CPU-owned registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
      cmp_q    <= '0;
    end else begin
      if (wr_reload) begin
        reload_q <= bus.io_writedata;
      end
      if (wr_cmp) begin
        cmp_q <= bus.io_writedata;
      end
    end
  end

  // Sticky flags: write-1-to-clear, with a same-cycle hardware set taking precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      cmf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !ovf_clr);
      cmf_q <= cmf_set || (cmf_q && !cmf_clr);
    end
  end

  assign rd_hit = (bus.io_readaddr[4:3] == BANK);
  assign rd_off = reg_off_e'(bus.io_readaddr[2:0]);

  // Read mux over the pre-write register state; no bypass from the write port.
  always_comb begin
    rd_mux = 8'h00;
    case (rd_off)
      OFF_CTRL:   rd_mux = ctrl_q;
      OFF_STAT:   rd_mux = {6'b0, cmf_q, ovf_q};
      OFF_COUNT:  rd_mux = count_q;
      OFF_RELOAD: rd_mux = reload_q;
      OFF_CMP:    rd_mux = cmp_q;
      OFF_PRESC:  rd_mux = presc_count;
      default:    rd_mux = 8'h00;
    endcase
  end

  // Read data register; holds during pause and returns zero for another bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (!pause) begin
      rdata_q <= rd_hit ? rd_mux : 8'h00;
    end
  end

  assign bus.io_readdata = rdata_q;
  assign irq             = ctrl_q.ie && (ovf_q || cmf_q);

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: two instances (bank 0 and bank 1) on a shared stimulus bus.
// Latency: reads are checked one edge after the address is presented.
// Backpressure: pause is driven explicitly by the pause scenario only.
module tb_io_timer;
  import io_timer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic [4:0] rd_addr;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       irq0;
  logic       irq1;

  int n_checks = 0;
  int n_fail   = 0;

  io_timer_if bus0 ();
  io_timer_if bus1 ();

  assign bus0.io_readaddr  = rd_addr;
  assign bus0.io_writeaddr = wr_addr;
  assign bus0.io_writedata = wr_data;
  assign bus0.io_write_en  = wr_en;
  assign bus1.io_readaddr  = rd_addr;
  assign bus1.io_writeaddr = wr_addr;
  assign bus1.io_writedata = wr_data;
  assign bus1.io_write_en  = wr_en;

  io_timer #(.BANK(2'd0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .bus   (bus0),
    .irq   (irq0)
  );

  io_timer #(.BANK(2'd1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .bus   (bus1),
    .irq   (irq1)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] A_CTRL   = 5'b00_000;
  localparam logic [4:0] A_STAT   = 5'b00_001;
  localparam logic [4:0] A_COUNT  = 5'b00_010;
  localparam logic [4:0] A_RELOAD = 5'b00_011;
  localparam logic [4:0] A_CMP    = 5'b00_100;
  localparam logic [4:0] A_PRESC  = 5'b00_101;
  localparam logic [4:0] A_RSVD6  = 5'b00_110;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pause   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    step();
    step();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq0); end
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", bus0.io_readdata); end
    for (int o = 0; o < 8; o++) begin
      rd_addr = {2'b00, 3'(o)};
      step();
      n_checks++;
      if (bus0.io_readdata !== 8'h00) begin
        n_fail++; $display("FAIL reset_reg off=%0d got=%h exp=00", o, bus0.io_readdata);
      end
    end
  endtask

  task automatic test_write_masks();
    do_reset();
    wr(A_CTRL, 8'hF8);
    rd_addr = A_CTRL; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h38) begin n_fail++; $display("FAIL ctrl_rsvd got=%h exp=38", bus0.io_readdata); end
    wr(A_PRESC, 8'hAA);
    rd_addr = A_PRESC; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL presc_ro got=%h exp=00", bus0.io_readdata); end
    wr(A_STAT, 8'hFC);
    rd_addr = A_STAT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL stat_hi got=%h exp=00", bus0.io_readdata); end
    wr(A_RSVD6, 8'h55);
    rd_addr = A_RSVD6; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL off6 got=%h exp=00", bus0.io_readdata); end
  endtask

  task automatic test_overflow_reload();
    logic [7:0] exp_seq [3] = '{8'hFF, 8'hF0, 8'hF1};
    do_reset();
    wr(A_RELOAD, 8'hF0);
    wr(A_COUNT, 8'hFE);
    rd_addr = A_COUNT;
    wr(A_CTRL, 8'h03);
    step();
    n_checks++;
    if (bus0.io_readdata !== 8'hFE) begin n_fail++; $display("FAIL ovf_start got=%h exp=fe", bus0.io_readdata); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus0.io_readdata !== exp_seq[i]) begin
        n_fail++; $display("FAIL ovf_seq idx=%0d got=%h exp=%h", i, bus0.io_readdata, exp_seq[i]);
      end
    end
    rd_addr = A_STAT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h01) begin n_fail++; $display("FAIL ovf_flag got=%h exp=01", bus0.io_readdata); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_masked got=%b exp=0", irq0); end
  endtask

  task automatic test_compare_irq();
    logic [7:0] exp_cnt [7] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};
    logic       exp_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    wr(A_CMP, 8'h03);
    wr(A_COUNT, 8'h00);
    rd_addr = A_COUNT;
    wr(A_CTRL, 8'h0D);
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (bus0.io_readdata !== exp_cnt[k]) begin
        n_fail++; $display("FAIL cmp_count k=%0d got=%h exp=%h", k, bus0.io_readdata, exp_cnt[k]);
      end
      n_checks++;
      if (irq0 !== exp_irq[k]) begin
        n_fail++; $display("FAIL cmp_irq k=%0d got=%b exp=%b", k, irq0, exp_irq[k]);
      end
    end
    wr(A_STAT, 8'h02);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL cmf_clear_irq got=%b exp=0", irq0); end
    rd_addr = A_STAT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL cmf_clear_stat got=%h exp=00", bus0.io_readdata); end
  endtask

  task automatic test_collisions();
    do_reset();
    wr(A_CMP, 8'hAA);
    rd_addr = A_COUNT;
    wr(A_CTRL, 8'h01);
    step(); step(); step();
    wr(A_COUNT, 8'h55);
    step();
    n_checks++;
    if (bus0.io_readdata !== 8'h55) begin n_fail++; $display("FAIL wr_vs_tick got=%h exp=55", bus0.io_readdata); end
    step();
    n_checks++;
    if (bus0.io_readdata !== 8'h56) begin n_fail++; $display("FAIL wr_then_tick got=%h exp=56", bus0.io_readdata); end
    wr(A_COUNT, 8'hFE);
    step();
    wr(A_STAT, 8'h01);
    rd_addr = A_STAT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h01) begin n_fail++; $display("FAIL set_beats_clear got=%h exp=01", bus0.io_readdata); end
    wr(A_STAT, 8'h01);
    step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL w1c_ovf got=%h exp=00", bus0.io_readdata); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL coll_irq got=%b exp=0", irq0); end
  endtask

  task automatic test_pause();
    do_reset();
    rd_addr = A_COUNT;
    wr(A_CTRL, 8'h01);
    step(); step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) wr(A_CMP, 8'h99);
      else        step();
      n_checks++;
      if (bus0.io_readdata !== 8'h01) begin
        n_fail++; $display("FAIL pause_hold i=%0d got=%h exp=01", i, bus0.io_readdata);
      end
    end
    pause = 1'b0;
    step();
    n_checks++;
    if (bus0.io_readdata !== 8'h02) begin n_fail++; $display("FAIL pause_count got=%h exp=02", bus0.io_readdata); end
    rd_addr = A_PRESC; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h03) begin n_fail++; $display("FAIL pause_presc got=%h exp=03", bus0.io_readdata); end
    rd_addr = A_COUNT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h04) begin n_fail++; $display("FAIL pause_resume got=%h exp=04", bus0.io_readdata); end
    rd_addr = A_CMP; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h99) begin n_fail++; $display("FAIL pause_write got=%h exp=99", bus0.io_readdata); end
  endtask

  task automatic test_bank();
    do_reset();
    wr(5'b01_010, 8'h77);
    wr(5'b00_010, 8'h12);
    rd_addr = 5'b01_010; step();
    n_checks++;
    if (bus1.io_readdata !== 8'h77) begin n_fail++; $display("FAIL bank1_count got=%h exp=77", bus1.io_readdata); end
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL bank0_miss got=%h exp=00", bus0.io_readdata); end
    rd_addr = 5'b00_010; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h12) begin n_fail++; $display("FAIL bank0_count got=%h exp=12", bus0.io_readdata); end
    n_checks++;
    if (bus1.io_readdata !== 8'h00) begin n_fail++; $display("FAIL bank1_miss got=%h exp=00", bus1.io_readdata); end
    rd_addr = 5'b01_110; step();
    n_checks++;
    if (bus1.io_readdata !== 8'h00) begin n_fail++; $display("FAIL bank1_off6 got=%h exp=00", bus1.io_readdata); end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    wr(A_COUNT, 8'hFE);
    wr(A_CTRL, 8'h07);
    step(); step();
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got=%b exp=1", irq0); end
    reset   = 1'b1;
    pause   = 1'b1;
    wr_addr = A_CTRL;
    wr_data = 8'h07;
    wr_en   = 1'b1;
    step();
    reset = 1'b0;
    pause = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq got=%b exp=0", irq0); end
    for (int o = 0; o < 6; o++) begin
      rd_addr = {2'b00, 3'(o)};
      step();
      n_checks++;
      if (bus0.io_readdata !== 8'h00) begin
        n_fail++; $display("FAIL post_reset_reg off=%0d got=%h exp=00", o, bus0.io_readdata);
      end
    end
    repeat (5) step();
    rd_addr = A_COUNT; step();
    n_checks++;
    if (bus0.io_readdata !== 8'h00) begin n_fail++; $display("FAIL post_reset_idle got=%h exp=00", bus0.io_readdata); end
  endtask

  initial begin
    test_reset();
    test_write_masks();
    test_overflow_reload();
    test_compare_irq();
    test_collisions();
    test_pause();
    test_bank();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
